// File: rtl/fifo_ctrl_1024x8.sv
// 1024x8 FIFO controller driving an external dual-port RAM (port 1 write, port 2 read).
// Occupancy is held in a counter; status flags are registered from the next-count value.
module fifo_ctrl_1024x8 #(
  parameter int unsigned ALMOST_FULL_TH  = 32'd1020,
  parameter int unsigned ALMOST_EMPTY_TH = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        full,
  output logic        empty,
  output logic        almost_full,
  output logic        almost_empty,
  output logic [10:0] count,
  output logic        overflow,
  output logic        underflow,
  output logic        ram_wen1,
  output logic [9:0]  ram_addr1,
  output logic [7:0]  ram_din1,
  output logic        ram_wen2,
  output logic [9:0]  ram_addr2,
  output logic [7:0]  ram_din2,
  input  logic [7:0]  ram_dout2
);

  localparam logic [10:0] AF_TH_C = 11'(ALMOST_FULL_TH);
  localparam logic [10:0] AE_TH_C = 11'(ALMOST_EMPTY_TH);
  localparam logic [10:0] DEPTH_C = 11'd1024;

  logic [10:0] wr_ptr_r;
  logic [10:0] rd_ptr_r;
  logic [10:0] count_r;
  logic [10:0] count_nxt_s;
  logic        full_r;
  logic        empty_r;
  logic        almost_full_r;
  logic        almost_empty_r;
  logic        overflow_r;
  logic        underflow_r;
  logic        rd_valid_r;
  logic        push_s;
  logic        pop_s;

  // Accept/reject push and pop, and compute the next occupancy
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    count_nxt_s = count_r;
    if (rst) begin
      push_s      = 1'b0;
      pop_s       = 1'b0;
      count_nxt_s = 11'd0;
    end else begin
      push_s = wr_en & ~full_r;
      pop_s  = rd_en & ~empty_r;
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + 11'd1;
        2'b01:   count_nxt_s = count_r - 11'd1;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointers, occupancy, status flags, sticky errors and read-valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r       <= 11'd0;
      rd_ptr_r       <= 11'd0;
      count_r        <= 11'd0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
      rd_valid_r     <= 1'b0;
    end else begin
      // 11-bit pointers: low 10 bits address RAM, MSB toggles on wrap
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 11'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 11'd1;
      end
      count_r        <= count_nxt_s;
      full_r         <= (count_nxt_s == DEPTH_C);
      empty_r        <= (count_nxt_s == 11'd0);
      almost_full_r  <= (count_nxt_s >= AF_TH_C);
      almost_empty_r <= (count_nxt_s <= AE_TH_C);
      if (wr_en && full_r) begin
        overflow_r <= 1'b1;
      end
      if (rd_en && empty_r) begin
        underflow_r <= 1'b1;
      end
      rd_valid_r <= pop_s;
    end
  end

  assign rd_data      = ram_dout2;
  assign rd_valid     = rd_valid_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  assign ram_wen1  = push_s;
  assign ram_addr1 = wr_ptr_r[9:0];
  assign ram_din1  = wr_data;
  assign ram_wen2  = 1'b0;
  assign ram_addr2 = rd_ptr_r[9:0];
  assign ram_din2  = 8'd0;

endmodule

// File: tb/tb_fifo_ctrl_1024x8.sv
// Randomized + directed scoreboard bench for fifo_ctrl_1024x8 with a behavioural RAM
// and a queue-based reference model of the FIFO.
module tb_fifo_ctrl_1024x8;

  localparam int AF_TH = 1020;
  localparam int AE_TH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [10:0] count;
  logic        overflow;
  logic        underflow;
  logic        ram_wen1;
  logic [9:0]  ram_addr1;
  logic [7:0]  ram_din1;
  logic        ram_wen2;
  logic [9:0]  ram_addr2;
  logic [7:0]  ram_din2;
  logic [7:0]  ram_dout2;

  fifo_ctrl_1024x8 #(.ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .ram_wen1(ram_wen1), .ram_addr1(ram_addr1), .ram_din1(ram_din1),
    .ram_wen2(ram_wen2), .ram_addr2(ram_addr2), .ram_din2(ram_din2),
    .ram_dout2(ram_dout2)
  );

  always #5 clk = ~clk;

  // Behavioural 1024x8 dual-port RAM with registered read on port 2
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (ram_wen1) mem[ram_addr1] <= ram_din1;
    ram_dout2 <= mem[ram_addr2];
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  int  wr_idx;
  int  rd_idx;
  bit  ovf_m;
  bit  unf_m;
  bit  exp_rv;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_q.delete();
    wr_idx = 0;
    rd_idx = 0;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    exp_rv = 1'b0;
  endtask

  // One clock cycle: drive, check RAM-side combinational outputs, clock, update model
  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit rs);
    bit wa;
    bit pa;
    wr_en = w; wr_data = d; rd_en = r; rst = rs;
    #1;
    wa = !rs && w && (q.size() < 1024);
    pa = !rs && r && (q.size() > 0);
    chk("ram_wen1", ram_wen1, wa);
    if (wa) begin
      chk("ram_addr1", ram_addr1, wr_idx);
      chk("ram_din1", ram_din1, d);
    end
    chk("ram_addr2", ram_addr2, rd_idx);
    chk("ram_port2_tied", {ram_wen2, ram_din2}, 0);
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (w && q.size() == 1024) ovf_m = 1'b1;
      if (r && q.size() == 0)    unf_m = 1'b1;
      if (pa) begin
        exp_q.push_back(q.pop_front());
        rd_idx = (rd_idx + 1) % 1024;
      end
      if (wa) begin
        q.push_back(d);
        wr_idx = (wr_idx + 1) % 1024;
      end
      exp_rv = pa;
    end
    #1;
  endtask

  // Monitor: compare status against the model and pop the scoreboard on read data
  always @(negedge clk) begin
    if (mon_en) begin
      logic [7:0] e;
      chk("count", count, q.size());
      chk("full", full, q.size() == 1024);
      chk("empty", empty, q.size() == 0);
      chk("almost_full", almost_full, q.size() >= AF_TH);
      chk("almost_empty", almost_empty, q.size() <= AE_TH);
      chk("overflow", overflow, ovf_m);
      chk("underflow", underflow, unf_m);
      chk("rd_valid", rd_valid, exp_rv);
      if (exp_rv && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (rd_valid) chk("rd_data", rd_data, e);
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    mon_en = 1'b1;

    // Three pushes then three back-to-back pops
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full from a fresh reset, then one overflowing push
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 1024; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);

    // Push+pop at full, then drain across the pointer wrap
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 1023; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Push+pop at empty, then read the word back
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset asserted in the middle of popping with five words stored
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic with shifting push/pop bias and rare resets
    for (int seg = 0; seg < 6; seg++) begin
      int wp;
      int rp;
      wp = (seg % 2 == 0) ? 75 : 35;
      rp = (seg % 2 == 0) ? 35 : 75;
      for (int i = 0; i < 500; i++) begin
        cyc($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
            $urandom_range(0, 399) == 0);
      end
    end

    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
